vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
- REQ-001: Parameter H_ACTIVE, default 640, visible pixels per line.
- REQ-002: Parameter H_FRONT, default 16; H_SYNC, default 96; H_BACK, default 48; horizontal blanking widths in pixels.
- REQ-003: Parameter V_ACTIVE, default 480; V_FRONT, default 10; V_SYNC, default 2; V_BACK, default 33; vertical widths in lines.
- REQ-004: Parameter SYNC_POL, default 0, sync level while in the sync interval; 0 = active-low, the TinyVGA PMOD convention.
- REQ-005: clk  input  1  pixel clock; one clock with no other clock domains.
- REQ-006: rst_n  input  1  reset, asynchronous assert, active-low.
- REQ-007: ce  input  1  pixel-advance enable; the timebase advances only on cycles where ce=1.
- REQ-008: hsync  output  1  horizontal sync, registered.
- REQ-009: vsync  output  1  vertical sync, registered.
- REQ-010: display_on  output  1  high when hpos < H_ACTIVE and vpos < V_ACTIVE.
- REQ-011: hpos  output  10  current pixel column, 0 .. H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (800 by default).
- REQ-012: vpos  output  10  current line, 0 .. V_TOTAL-1, where V_TOTAL is the sum of the V_ parameters (525 by default).
- REQ-013: line_start  output  1  one-cycle strobe while hpos=0.
- REQ-014: frame_start  output  1  one-cycle strobe while hpos=0 and vpos=0.
- REQ-015: frame_count  output  8  frames started since reset, wrapping modulo 256.

Function
- REQ-016: Each axis SHALL run a four-state phase FSM: ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE, with each phase lasting its parameter count.
- REQ-017: On each ce=1 cycle, hpos SHALL increment by 1; at H_TOTAL-1 it SHALL wrap to 0.
- REQ-018: vpos SHALL advance only on ce=1 cycles where hpos wraps; at V_TOTAL-1 it SHALL wrap to 0.
- REQ-019: hsync SHALL equal SYNC_POL exactly for hpos in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1] (656..751 by default), and ~SYNC_POL otherwise.
- REQ-020: vsync SHALL equal SYNC_POL exactly for vpos in [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC-1] (490..491 by default), independent of hpos.
- REQ-021: All outputs SHALL be registers, mutually consistent in the same cycle: zero-latency relation to hpos/vpos, with no combinational path from ce.
- REQ-022: line_start and frame_start SHALL each be high for exactly one ce=1 cycle per occurrence; while ce=0 they SHALL be 0.
- REQ-023: frame_count SHALL increment in the same cycle frame_start asserts, and wrap from 255 to 0.
- REQ-024: With ce=0, hpos, vpos, the FSM states, sync outputs, display_on and frame_count SHALL hold.
- REQ-025: A ce toggle on any cycle, including a wrap cycle, SHALL NOT skip or repeat a position.
- REQ-026: Arithmetic SHALL be unsigned 10-bit, with no intermediate wider than 10 bits, and SHALL never exceed 1023.

Reset
- REQ-027: While rst_n=0: hpos=H_TOTAL-1, vpos=V_TOTAL-1, both FSMs in BACK, hsync=vsync=~SYNC_POL, display_on=0, line_start=frame_start=0, frame_count=0.
- REQ-028: The first ce=1 cycle after release SHALL move to hpos=0, vpos=0, with display_on=1, line_start=1, frame_start=1, frame_count=1.
- REQ-029: Reset asserted mid-frame SHALL return all state to REQ-027 values immediately, without waiting for a clock edge.

Structure
- REQ-030: Default timing constants, the derived H_TOTAL/V_TOTAL and the phase enum (ACTIVE, FRONT, SYNC, BACK) SHALL live in shared package vga_timing_pkg.
- REQ-031: Each axis SHALL be one instance of sub-module vga_axis_counter (position counter, phase FSM, sync decode, wrap output), instantiated twice.
- REQ-032: The vertical instance's advance input SHALL be the horizontal instance's wrap output ANDed with ce.

Verification
- REQ-033: Release reset, ce=1 -> first cycle hpos=0, vpos=0, frame_start=1; frame_start repeats every 420000 cycles.
- REQ-034: Count over one line -> hsync low exactly 96 cycles starting at hpos=656; display_on high exactly 640 cycles.
- REQ-035: Count over one frame -> vsync low for lines 490 and 491 only (1600 cycles); line_start pulses 525 times.
- REQ-036: ce pattern 1,0,0,1 around hpos=799 -> hpos holds 799 on the two ce=0 cycles, then reaches 0; vpos advances exactly once.
- REQ-037: Run 256 frames -> frame_count wraps 255 to 0 on the 256th frame_start.
- REQ-038: Assert rst_n=0 at hpos=300, vpos=200 -> outputs match REQ-027 before the next clk edge.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// ============================================================================
// Module : vga_timing_pkg
// Brief  : Shared VGA timing constants, phase encoding and position helper.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_timing_pkg;

    localparam int c_POS_W    = 10;

    localparam int c_H_ACTIVE = 640;
    localparam int c_H_FRONT  = 16;
    localparam int c_H_SYNC   = 96;
    localparam int c_H_BACK   = 48;
    localparam int c_H_TOTAL  = c_H_ACTIVE + c_H_FRONT + c_H_SYNC + c_H_BACK;

    localparam int c_V_ACTIVE = 480;
    localparam int c_V_FRONT  = 10;
    localparam int c_V_SYNC   = 2;
    localparam int c_V_BACK   = 33;
    localparam int c_V_TOTAL  = c_V_ACTIVE + c_V_FRONT + c_V_SYNC + c_V_BACK;

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_t;

    // Increment with wrap at i_last; the sum never leaves 10 bits.
    function automatic logic [c_POS_W-1:0] f_wrap_inc(
        input logic [c_POS_W-1:0] i_pos,
        input logic [c_POS_W-1:0] i_last
    );
        return (i_pos == i_last) ? '0 : i_pos + 10'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vga_axis_counter.sv
// ============================================================================
// Module : vga_axis_counter
// Brief  : One timing axis - position counter, phase FSM, registered sync.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int   ACTIVE   = c_H_ACTIVE,
    parameter int   FRONT    = c_H_FRONT,
    parameter int   SYNC     = c_H_SYNC,
    parameter int   BACK     = c_H_BACK,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_advance,
    output logic [c_POS_W-1:0] o_pos,
    output phase_t             o_phase_nxt,
    output logic               o_sync,
    output logic               o_wrap
);

    localparam logic [c_POS_W-1:0] c_ACT_LAST   = c_POS_W'(ACTIVE - 1);
    localparam logic [c_POS_W-1:0] c_FRONT_LAST = c_POS_W'(ACTIVE + FRONT - 1);
    localparam logic [c_POS_W-1:0] c_SYNC_LAST  = c_POS_W'(ACTIVE + FRONT + SYNC - 1);
    localparam logic [c_POS_W-1:0] c_LAST       = c_POS_W'(ACTIVE + FRONT + SYNC + BACK - 1);

    logic [c_POS_W-1:0] r_pos;
    logic [c_POS_W-1:0] w_pos_nxt;
    phase_t             r_state;
    phase_t             w_state_nxt;
    logic               r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pos   <= c_LAST;
            r_state <= PH_BACK;
            r_sync  <= ~SYNC_POL;
        end else begin
            r_pos   <= w_pos_nxt;
            r_state <= w_state_nxt;
            // Decoded from the next phase so sync lines up with the new position.
            r_sync  <= (w_state_nxt == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
        end
    end

    always_comb begin
        w_pos_nxt   = r_pos;
        w_state_nxt = r_state;
        if (i_advance) begin
            w_pos_nxt = f_wrap_inc(r_pos, c_LAST);
            case (r_state)
                PH_ACTIVE: if (r_pos == c_ACT_LAST)   w_state_nxt = PH_FRONT;
                PH_FRONT:  if (r_pos == c_FRONT_LAST) w_state_nxt = PH_SYNC;
                PH_SYNC:   if (r_pos == c_SYNC_LAST)  w_state_nxt = PH_BACK;
                PH_BACK:   if (r_pos == c_LAST)       w_state_nxt = PH_ACTIVE;
            endcase
        end
    end

    assign o_pos       = r_pos;
    assign o_phase_nxt = w_state_nxt;
    assign o_sync      = r_sync;
    assign o_wrap      = (r_pos == c_LAST);

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ============================================================================
// Module : vga_timing_gen
// Brief  : VGA raster timebase with registered syncs, strobes and frame count.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = c_H_ACTIVE,
    parameter int   H_FRONT  = c_H_FRONT,
    parameter int   H_SYNC   = c_H_SYNC,
    parameter int   H_BACK   = c_H_BACK,
    parameter int   V_ACTIVE = c_V_ACTIVE,
    parameter int   V_FRONT  = c_V_FRONT,
    parameter int   V_SYNC   = c_V_SYNC,
    parameter int   V_BACK   = c_V_BACK,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ce,
    output logic               hsync,
    output logic               vsync,
    output logic               display_on,
    output logic [c_POS_W-1:0] hpos,
    output logic [c_POS_W-1:0] vpos,
    output logic               line_start,
    output logic               frame_start,
    output logic [7:0]         frame_count
);

    phase_t w_h_phase_nxt;
    phase_t w_v_phase_nxt;
    logic   w_h_wrap;
    logic   w_v_wrap;
    logic   w_v_adv;

    logic       r_display_on;
    logic       r_line_start;
    logic       r_frame_start;
    logic [7:0] r_frame_count;

    assign w_v_adv = w_h_wrap & ce;

    vga_axis_counter #(
        .ACTIVE   (H_ACTIVE),
        .FRONT    (H_FRONT),
        .SYNC     (H_SYNC),
        .BACK     (H_BACK),
        .SYNC_POL (SYNC_POL)
    ) u_h_axis (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_advance   (ce),
        .o_pos       (hpos),
        .o_phase_nxt (w_h_phase_nxt),
        .o_sync      (hsync),
        .o_wrap      (w_h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE   (V_ACTIVE),
        .FRONT    (V_FRONT),
        .SYNC     (V_SYNC),
        .BACK     (V_BACK),
        .SYNC_POL (SYNC_POL)
    ) u_v_axis (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_advance   (w_v_adv),
        .o_pos       (vpos),
        .o_phase_nxt (w_v_phase_nxt),
        .o_sync      (vsync),
        .o_wrap      (w_v_wrap)
    );

    // Next-phase inputs already hold when ce=0, so display_on holds too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_display_on  <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_count <= 8'd0;
        end else begin
            r_display_on  <= (w_h_phase_nxt == PH_ACTIVE) && (w_v_phase_nxt == PH_ACTIVE);
            r_line_start  <= ce & w_h_wrap;
            r_frame_start <= ce & w_h_wrap & w_v_wrap;
            if (ce && w_h_wrap && w_v_wrap) begin
                r_frame_count <= r_frame_count + 8'd1;
            end
        end
    end

    assign display_on  = r_display_on;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign frame_count = r_frame_count;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// ============================================================================
// Module : tb_vga_timing_gen
// Brief  : Directed bench for vga_timing_gen on a compact raster.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_timing_gen;

    // Compact raster: H 10+2+3+2 = 17 (sync 12..14), V 5+1+2+1 = 9 (sync 6..7),
    // so 256 frames of 153 cycles stay within a short run.
    localparam int c_HT    = 17;
    localparam int c_VT    = 9;
    localparam int c_FRAME = 153;

    logic       clk;
    logic       rst_n;
    logic       ce;
    logic       hsync;
    logic       vsync;
    logic       display_on;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       line_start;
    logic       frame_start;
    logic [7:0] frame_count;

    int n_tests = 0;
    int n_fail  = 0;

    vga_timing_gen #(
        .H_ACTIVE (10), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
        .V_ACTIVE (5),  .V_FRONT (1), .V_SYNC (2), .V_BACK (1),
        .SYNC_POL (1'b0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ce          (ce),
        .hsync       (hsync),
        .vsync       (vsync),
        .display_on  (display_on),
        .hpos        (hpos),
        .vpos        (vpos),
        .line_start  (line_start),
        .frame_start (frame_start),
        .frame_count (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " hpos"},        32'(hpos),        32'd16);
        chk({tag, " vpos"},        32'(vpos),        32'd8);
        chk({tag, " hsync"},       32'(hsync),       32'd1);
        chk({tag, " vsync"},       32'(vsync),       32'd1);
        chk({tag, " display_on"},  32'(display_on),  32'd0);
        chk({tag, " line_start"},  32'(line_start),  32'd0);
        chk({tag, " frame_start"}, 32'(frame_start), 32'd0);
        chk({tag, " frame_count"}, 32'(frame_count), 32'd0);
    endtask

    task automatic chk_first(input string tag);
        chk({tag, " hpos"},        32'(hpos),        32'd0);
        chk({tag, " vpos"},        32'(vpos),        32'd0);
        chk({tag, " display_on"},  32'(display_on),  32'd1);
        chk({tag, " line_start"},  32'(line_start),  32'd1);
        chk({tag, " frame_start"}, 32'(frame_start), 32'd1);
        chk({tag, " frame_count"}, 32'(frame_count), 32'd1);
        chk({tag, " hsync"},       32'(hsync),       32'd1);
        chk({tag, " vsync"},       32'(vsync),       32'd1);
    endtask

    initial begin
        int hs_low, hs_first, disp_cnt, ls_cnt, fs_cnt, fs_idx, vs_low, errs, seq_err;
        int eh, ev, guard;
        logic [7:0] exp_fc;
        logic       wrapped;
        logic       e_hs, e_vs, e_disp;

        // Reset state
        rst_n = 1'b0;
        ce    = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset("reset");
        ce = 1'b1;
        @(negedge clk);
        chk_reset("reset_ce1");

        // First ce cycle after release
        rst_n = 1'b1;
        @(negedge clk);
        chk_first("first");

        // One line starting at hpos=0, vpos=0
        hs_low = 0; hs_first = -1; disp_cnt = 0; ls_cnt = 0; seq_err = 0;
        for (int i = 0; i < c_HT; i++) begin
            if (hpos != 10'(i) || vpos != 10'd0) seq_err++;
            if (hsync == 1'b0) begin
                hs_low++;
                if (hs_first < 0) hs_first = int'(hpos);
            end
            if (display_on) disp_cnt++;
            if (line_start) ls_cnt++;
            @(negedge clk);
        end
        chk("line_seq",      32'(seq_err),  32'd0);
        chk("hsync_low_cnt", 32'(hs_low),   32'd3);
        chk("hsync_first",   32'(hs_first), 32'd12);
        chk("display_cnt",   32'(disp_cnt), 32'd10);
        chk("line_ls_cnt",   32'(ls_cnt),   32'd1);

        // One full frame period starting at (0,1), against an independent model
        eh = 0; ev = 1; errs = 0; vs_low = 0; ls_cnt = 0; fs_cnt = 0; fs_idx = -1;
        for (int i = 0; i < c_FRAME; i++) begin
            e_hs   = !(eh >= 12 && eh <= 14);
            e_vs   = !(ev >= 6 && ev <= 7);
            e_disp = (eh < 10) && (ev < 5);
            if (hpos != 10'(eh) || vpos != 10'(ev)) errs++;
            if (hsync !== e_hs || vsync !== e_vs || display_on !== e_disp) errs++;
            if (line_start !== (eh == 0) || frame_start !== (eh == 0 && ev == 0)) errs++;
            if (!vsync) vs_low++;
            if (line_start) ls_cnt++;
            if (frame_start) begin
                fs_cnt++;
                fs_idx = i;
            end
            eh = (eh == c_HT - 1) ? 0 : eh + 1;
            if (eh == 0) ev = (ev == c_VT - 1) ? 0 : ev + 1;
            @(negedge clk);
        end
        chk("frame_model_errs", 32'(errs),   32'd0);
        chk("vsync_low_cnt",    32'(vs_low), 32'd34);
        chk("frame_ls_cnt",     32'(ls_cnt), 32'd9);
        chk("frame_fs_cnt",     32'(fs_cnt), 32'd1);
        chk("frame_fs_period",  32'(fs_idx), 32'd136);
        chk("frame_count_2",    32'(frame_count), 32'd2);

        // ce 1,0,0,1 around the end of a line
        guard = 0;
        while (hpos != 10'd16 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        chk("reach_h16", 32'(hpos), 32'd16);
        chk("reach_v1",  32'(vpos), 32'd1);
        ce = 1'b0;
        @(negedge clk);
        chk("hold1_hpos", 32'(hpos), 32'd16);
        chk("hold1_vpos", 32'(vpos), 32'd1);
        chk("hold1_ls",   32'(line_start), 32'd0);
        @(negedge clk);
        chk("hold2_hpos", 32'(hpos), 32'd16);
        chk("hold2_vpos", 32'(vpos), 32'd1);
        ce = 1'b1;
        @(negedge clk);
        chk("wrap_hpos", 32'(hpos), 32'd0);
        chk("wrap_vpos", 32'(vpos), 32'd2);
        chk("wrap_ls",   32'(line_start), 32'd1);
        chk("wrap_fs",   32'(frame_start), 32'd0);
        ce = 1'b0;
        @(negedge clk);
        chk("hold0_hpos", 32'(hpos), 32'd0);
        chk("hold0_ls",   32'(line_start), 32'd0);
        chk("hold0_disp", 32'(display_on), 32'd1);
        chk("hold0_fc",   32'(frame_count), 32'd2);
        ce = 1'b1;
        @(negedge clk);
        chk("resume_hpos", 32'(hpos), 32'd1);
        chk("resume_vpos", 32'(vpos), 32'd2);

        // Run until frame_count wraps 255 -> 0
        exp_fc = 8'd2; errs = 0; wrapped = 1'b0; guard = 0;
        while (!wrapped && guard < 256 * c_FRAME + 400) begin
            if (frame_start) begin
                exp_fc = exp_fc + 8'd1;
                if (frame_count !== exp_fc) errs++;
                if (exp_fc == 8'd0) wrapped = 1'b1;
            end else if (frame_count !== exp_fc) begin
                errs++;
            end
            if (!wrapped) @(negedge clk);
            guard++;
        end
        chk("fc_wrap_seen", 32'(wrapped), 32'd1);
        chk("fc_track_errs", 32'(errs), 32'd0);
        chk("fc_wrap_value", 32'(frame_count), 32'd0);

        // Asynchronous reset mid-frame at (5,3)
        guard = 0;
        while (!(hpos == 10'd5 && vpos == 10'd3) && guard < 2 * c_FRAME) begin
            @(negedge clk);
            guard++;
        end
        chk("mid_hpos", 32'(hpos), 32'd5);
        chk("mid_vpos", 32'(vpos), 32'd3);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset("async");
        @(negedge clk);
        chk_reset("async_held");
        rst_n = 1'b1;
        @(negedge clk);
        chk_first("rerelease");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
